// File: rtl/arp_tx_sched.sv
// ARP transmit scheduler: filters ARP requests for LOCAL_IP, queues reply targets, and sequences the framer.
// Optional ARP_GRATUITOUS_EN: issue one gratuitous ARP as the first grant after every reset.
module arp_tx_sched #(
    parameter logic [31:0] LOCAL_IP  = 32'hC0A80102,
    parameter logic [47:0] LOCAL_MAC = 48'h020000000001,
    parameter logic [15:0] TIMEOUT   = 16'd1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_valid,
    input  logic [511:0] rx_frame,
    input  logic         host_req,
    input  logic [31:0]  host_tip,
    output logic         host_ack,
    output logic         tx_start,
    output logic [15:0]  tx_oper,
    output logic [47:0]  tx_dst,
    output logic [47:0]  tx_sha,
    output logic [47:0]  tx_tha,
    output logic [31:0]  tx_tpa,
    input  logic         tx_busy,
    input  logic         tx_done,
    output logic         tx_timeout,
    output logic [15:0]  reply_cnt,
    output logic [15:0]  drop_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
    typedef enum logic [1:0] {SRC_REPLY, SRC_HOST, SRC_GRAT} src_t;

    state_t      state, state_d;
    src_t        cur_src, grant_src;
    logic        grant, fire, retire, timed_out;
    logic        rr_host;
    logic [15:0] timer;
    logic        grat_pend;

    logic [79:0] q_mem [2];
    logic        q_rd, q_wr;
    logic [1:0]  q_cnt;
    logic        q_empty, q_full, push, pop, drop;
    logic        accept, host_pend;
    logic        unused_bits;

    assign unused_bits = ^{rx_frame[511:416], rx_frame[175:0]};

    assign accept = rx_valid
        && rx_frame[415:400] == 16'h0806 && rx_frame[399:384] == 16'h0001
        && rx_frame[383:368] == 16'h0800 && rx_frame[367:360] == 8'd6
        && rx_frame[359:352] == 8'd4     && rx_frame[351:336] == 16'h0001
        && rx_frame[207:176] == LOCAL_IP;

    assign q_empty = (q_cnt == 2'd0);
    assign q_full  = (q_cnt == 2'd2);
    // Host stays masked while its ack is out, so a held request is not granted twice.
    assign host_pend = host_req && !host_ack;
    assign pop  = retire && cur_src == SRC_REPLY;
    assign push = accept && (!q_full || pop);
    assign drop = accept && q_full && !pop;

    always_comb begin
        state_d   = state;
        grant     = 1'b0;
        grant_src = SRC_REPLY;
        fire      = 1'b0;
        retire    = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_busy) begin
                    if (grat_pend) begin
                        grant = 1'b1; grant_src = SRC_GRAT;
                    end else if (!q_empty && host_pend) begin
                        grant = 1'b1; grant_src = rr_host ? SRC_HOST : SRC_REPLY;
                    end else if (!q_empty) begin
                        grant = 1'b1; grant_src = SRC_REPLY;
                    end else if (host_pend) begin
                        grant = 1'b1; grant_src = SRC_HOST;
                    end
                end
                if (grant) state_d = ISSUE;
            end
            ISSUE: begin
                fire    = 1'b1;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    retire = 1'b1;
                end else if (timer == TIMEOUT - 16'd1) begin
                    retire    = 1'b1;
                    timed_out = 1'b1;
                end
                if (retire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ARP_GRATUITOUS_EN
    always_ff @(posedge clk) begin
        if (rst)                               grat_pend <= 1'b1;
        else if (grant && grant_src == SRC_GRAT) grat_pend <= 1'b0;
    end
`else
    assign grat_pend = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) q_mem[q_wr] <= {rx_frame[335:288], rx_frame[287:256]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_src    <= SRC_REPLY;
            rr_host    <= 1'b0;
            timer      <= '0;
            q_rd       <= 1'b0;
            q_wr       <= 1'b0;
            q_cnt      <= '0;
            host_ack   <= 1'b0;
            tx_start   <= 1'b0;
            tx_timeout <= 1'b0;
            tx_oper    <= '0;
            tx_dst     <= '0;
            tx_sha     <= '0;
            tx_tha     <= '0;
            tx_tpa     <= '0;
            reply_cnt  <= '0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_d;
            tx_start   <= fire;
            tx_timeout <= timed_out;
            host_ack   <= retire && cur_src == SRC_HOST;
            if (fire)                   timer <= '0;
            else if (state == WAIT_DONE) timer <= timer + 16'd1;

            if (grant) begin
                cur_src <= grant_src;
                tx_sha  <= LOCAL_MAC;
                case (grant_src)
                    SRC_REPLY: begin
                        tx_oper <= 16'd2;
                        tx_dst  <= q_mem[q_rd][79:32];
                        tx_tha  <= q_mem[q_rd][79:32];
                        tx_tpa  <= q_mem[q_rd][31:0];
                        rr_host <= 1'b1;
                    end
                    SRC_HOST: begin
                        tx_oper <= 16'd1;
                        tx_dst  <= '1;
                        tx_tha  <= '0;
                        tx_tpa  <= host_tip;
                        rr_host <= 1'b0;
                    end
                    default: begin
                        tx_oper <= 16'd1;
                        tx_dst  <= '1;
                        tx_tha  <= '0;
                        tx_tpa  <= LOCAL_IP;
                    end
                endcase
            end

            if (push) q_wr <= ~q_wr;
            if (pop)  q_rd <= ~q_rd;
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + 2'd1;
                2'b01:   q_cnt <= q_cnt - 2'd1;
                default: q_cnt <= q_cnt;
            endcase

            // A timed-out reply is retired but not counted as completed.
            if (pop && !timed_out && reply_cnt != 16'hFFFF) reply_cnt <= reply_cnt + 16'd1;
            if (drop && drop_cnt != 16'hFFFF)               drop_cnt  <= drop_cnt + 16'd1;
        end
    end
endmodule
